// File: rtl/conv_accel_pkg.sv
// Shared types and limits for the conv accelerator weight path.
// Holds the load FSM encoding and kernel-size checks.
package conv_accel_pkg;

  localparam int MAX_KERNEL = 16;
  localparam int STATE_W    = 2;
  localparam int KSIZE_W    = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic kernel_ok(
    input logic [KSIZE_W-1:0] k,
    input int unsigned        depth
  );
    return (k != '0) &&
           ({24'd0, k} <= depth);
  endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Config and weight-stream handshake bundle.
// master drives requests/data, slave answers.
interface weight_load_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  import conv_accel_pkg::*;

  logic               cfg_valid;
  logic [KSIZE_W-1:0] cfg_kernel_size;
  logic               cfg_ready;
  logic               cfg_err;

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (
    output cfg_valid,
    output cfg_kernel_size,
    input  cfg_ready,
    input  cfg_err,
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_kernel_size,
    output cfg_ready,
    output cfg_err,
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/load_counter.sv
// Nested word/buffer counter for a weight load.
// Words wrap at kernel size and step the buffer index.
module load_counter
  import conv_accel_pkg::*;
#(
  parameter int NUM_BUFS = 4,
  parameter int IDX_W    = idx_w(NUM_BUFS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [KSIZE_W-1:0] i_kernel_size,
  output logic [IDX_W-1:0]   o_buf_idx,
  output logic               o_last
);

  logic [KSIZE_W-1:0] r_word_cnt;
  logic [IDX_W-1:0]   r_buf_idx;
  logic               w_word_wrap;
  logic               w_idx_last;

  assign w_word_wrap =
    (r_word_cnt == (i_kernel_size - 8'd1));
  assign w_idx_last =
    (r_buf_idx == IDX_W'(NUM_BUFS - 1));
  assign o_last    = w_word_wrap & w_idx_last;
  assign o_buf_idx = r_buf_idx;

  // advance word count per beat, roll into next buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word_cnt <= '0;
      r_buf_idx  <= '0;
    end else if (i_clr) begin
      r_word_cnt <= '0;
      r_buf_idx  <= '0;
    end else if (i_en) begin
      if (w_word_wrap) begin
        r_word_cnt <= '0;
        r_buf_idx  <= w_idx_last ? '0
                    : r_buf_idx + 1'b1;
      end else begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight buffer load sequencer: IDLE -> LOAD -> RUN.
// Streams kernel_size words into each buffer, then reads.
module weight_load_ctrl
  import conv_accel_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_BUFS     = 4,
  parameter int BUFFER_DEPTH = MAX_KERNEL
) (
  input  logic                  clk,
  input  logic                  rstn,
  weight_load_ctrl_if.slave     bus,
  output logic [NUM_BUFS-1:0]   buf_wr_en,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  buf_rd_en,
  output logic                  weights_valid,
  input  logic                  pe_done,
  input  logic                  abort,
  output logic                  busy
);

  localparam int IDX_W = idx_w(NUM_BUFS);

  state_e r_state;
  state_e w_state_nxt;

  logic [KSIZE_W-1:0]    r_kernel_size;
  logic [NUM_BUFS-1:0]   r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_run;
  logic                  r_cfg_err;
  logic                  r_busy;

  logic [NUM_BUFS-1:0]   w_wr_en_nxt;
  logic [DATA_WIDTH-1:0] w_wr_data_nxt;
  logic                  w_run_nxt;
  logic                  w_cfg_err_nxt;
  logic                  w_cfg_take;
  logic                  w_clr;
  logic                  w_cnt_en;
  logic [IDX_W-1:0]      w_buf_idx;
  logic                  w_last;
  logic [NUM_BUFS-1:0]   w_onehot;

  // ready lines decode straight from state
  assign bus.cfg_ready = (r_state == ST_IDLE);
  assign bus.s_ready   = (r_state == ST_LOAD);
  assign bus.cfg_err   = r_cfg_err;

  assign buf_wr_en     = r_wr_en;
  assign buf_wr_data   = r_wr_data;
  assign buf_rd_en     = r_run;
  assign weights_valid = r_run;
  assign busy          = r_busy;

  load_counter #(
    .NUM_BUFS (NUM_BUFS),
    .IDX_W    (IDX_W)
  ) u_cnt (
    .clk           (clk),
    .rstn          (rstn),
    .i_clr         (w_clr),
    .i_en          (w_cnt_en),
    .i_kernel_size (r_kernel_size),
    .o_buf_idx     (w_buf_idx),
    .o_last        (w_last)
  );

  // one-hot strobe for the buffer being filled
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      w_onehot[i] = (w_buf_idx == IDX_W'(i));
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state and next registered outputs;
  // abort wins over every other event
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en_nxt   = '0;
    w_wr_data_nxt = r_wr_data;
    w_run_nxt     = 1'b0;
    w_cfg_err_nxt = 1'b0;
    w_cfg_take    = 1'b0;
    w_clr         = 1'b0;
    w_cnt_en      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_clr = 1'b1;
          if (bus.cfg_valid) begin
            if (kernel_ok(bus.cfg_kernel_size,
                          BUFFER_DEPTH)) begin
              w_cfg_take  = 1'b1;
              w_state_nxt = ST_LOAD;
            end else begin
              w_cfg_err_nxt = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (bus.s_valid) begin
            w_wr_en_nxt   = w_onehot;
            w_wr_data_nxt = bus.s_data;
            w_cnt_en      = 1'b1;
            if (w_last) begin
              w_state_nxt = ST_RUN;
              w_run_nxt   = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pe_done) w_state_nxt = ST_IDLE;
          else         w_run_nxt   = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // registered outputs and latched kernel size
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kernel_size <= '0;
      r_wr_en       <= '0;
      r_wr_data     <= '0;
      r_run         <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_cfg_take)
        r_kernel_size <= bus.cfg_kernel_size;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_run     <= w_run_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl.
// Hand-computed strobes and data per beat.
module tb_weight_load_ctrl;

  localparam int DW = 16;
  localparam int NB = 4;

  logic          clk;
  logic          rstn;
  logic [NB-1:0] buf_wr_en;
  logic [DW-1:0] buf_wr_data;
  logic          buf_rd_en;
  logic          weights_valid;
  logic          pe_done;
  logic          abort;
  logic          busy;

  int n_vec;
  int n_err;
  int writes;
  int nb;
  int wv_cnt;

  weight_load_ctrl_if #(.DATA_WIDTH(DW)) bus();

  weight_load_ctrl #(
    .DATA_WIDTH   (DW),
    .NUM_BUFS     (NB),
    .BUFFER_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus.slave),
    .buf_wr_en     (buf_wr_en),
    .buf_wr_data   (buf_wr_data),
    .buf_rd_en     (buf_rd_en),
    .weights_valid (weights_valid),
    .pe_done       (pe_done),
    .abort         (abort),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int k);
    bus.cfg_valid       = 1'b1;
    bus.cfg_kernel_size = 8'(k);
    step();
    bus.cfg_valid       = 1'b0;
  endtask

  task automatic do_load(
    input int k,
    input int base
  );
    cfg(k);
    chk("ld_busy", 32'(busy), 1);
    chk("ld_sready", 32'(bus.s_ready), 1);
    chk("ld_cfgrdy", 32'(bus.cfg_ready), 0);
    for (int n = 0; n < k * NB; n++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(base + n);
      step();
      chk("ld_en", 32'(buf_wr_en),
          32'(1) << (n / k));
      chk("ld_dat", 32'(buf_wr_data), base + n);
    end
    bus.s_valid = 1'b0;
    chk("run_sready", 32'(bus.s_ready), 0);
    chk("run_wv", 32'(weights_valid), 1);
    chk("run_rd", 32'(buf_rd_en), 1);
  endtask

  task automatic end_run();
    pe_done = 1'b1;
    step();
    pe_done = 1'b0;
    chk("done_wv", 32'(weights_valid), 0);
    chk("done_rd", 32'(buf_rd_en), 0);
    chk("done_rdy", 32'(bus.cfg_ready), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    pe_done = 1'b0;
    abort   = 1'b0;
    bus.cfg_valid       = 1'b0;
    bus.cfg_kernel_size = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfgrdy", 32'(bus.cfg_ready), 1);
    chk("rst_sready", 32'(bus.s_ready), 0);
    chk("rst_en", 32'(buf_wr_en), 0);
    chk("rst_dat", 32'(buf_wr_data), 0);
    chk("rst_wv", 32'(weights_valid), 0);
    chk("rst_err", 32'(bus.cfg_err), 0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // k=3, beats 1..12, then a 10-cycle RUN
    do_load(3, 1);
    wv_cnt = 1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (weights_valid) wv_cnt++;
      chk("run_rdy", 32'(bus.cfg_ready), 0);
    end
    chk("run_len", wv_cnt, 10);
    end_run();

    // rejected sizes
    cfg(0);
    chk("k0_err", 32'(bus.cfg_err), 1);
    chk("k0_busy", 32'(busy), 0);
    chk("k0_rdy", 32'(bus.cfg_ready), 1);
    step();
    chk("k0_pulse", 32'(bus.cfg_err), 0);
    cfg(17);
    chk("k17_err", 32'(bus.cfg_err), 1);
    chk("k17_busy", 32'(busy), 0);
    step();
    chk("k17_pulse", 32'(bus.cfg_err), 0);
    chk("k17_sready", 32'(bus.s_ready), 0);

    // k=2 with beats every other cycle
    cfg(2);
    nb = 0;
    writes = 0;
    for (int c = 0; c < 16; c++) begin
      bus.s_valid = (c % 2 == 0) && (nb < 8);
      bus.s_data  = 16'(100 + nb);
      step();
      if (buf_wr_en != 0) writes++;
      if (bus.s_valid) begin
        chk("gap_en", 32'(buf_wr_en),
            32'(1) << (nb / 2));
        chk("gap_dat", 32'(buf_wr_data), 100 + nb);
        nb++;
      end else begin
        chk("gap_idle", 32'(buf_wr_en), 0);
      end
    end
    bus.s_valid = 1'b0;
    chk("gap_writes", writes, 8);
    chk("gap_run", 32'(weights_valid), 1);
    end_run();

    // abort on 5th beat of k=4
    cfg(4);
    writes = 0;
    for (int n = 0; n < 4; n++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(200 + n);
      step();
      if (buf_wr_en != 0) writes++;
    end
    bus.s_data = 16'(204);
    abort      = 1'b1;
    step();
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    if (buf_wr_en != 0) writes++;
    chk("ab_writes", writes, 4);
    chk("ab_en", 32'(buf_wr_en), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rdy", 32'(bus.cfg_ready), 1);
    chk("ab_wv", 32'(weights_valid), 0);
    do_load(1, 300);
    end_run();

    // reset mid-LOAD, then reload
    cfg(2);
    for (int n = 0; n < 3; n++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(400 + n);
      step();
    end
    bus.s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mr_en", 32'(buf_wr_en), 0);
    chk("mr_dat", 32'(buf_wr_data), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_sready", 32'(bus.s_ready), 0);
    chk("mr_rdy", 32'(bus.cfg_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    step();
    do_load(2, 500);
    end_run();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
